// File: rtl/vscale_htif_pcr_responder.sv
// Core-side HTIF PCR responder: owns tohost/fromhost, serves one host request at a time
// and returns the register value seen before the access.
module vscale_htif_pcr_responder #(
    parameter int                    HTIF_PCR_WIDTH = 64,
    parameter int                    ADDR_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = 12'h780,
    parameter logic [ADDR_WIDTH-1:0] FROMHOST_ADDR  = 12'h781
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      htif_pcr_req_valid,
    output logic                      htif_pcr_req_ready,
    input  logic                      htif_pcr_req_rw,
    input  logic [ADDR_WIDTH-1:0]     htif_pcr_req_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    output logic                      htif_pcr_resp_valid,
    input  logic                      htif_pcr_resp_ready,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
    input  logic                      core_csr_wen,
    input  logic [ADDR_WIDTH-1:0]     core_csr_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] core_csr_wdata,
    output logic [HTIF_PCR_WIDTH-1:0] tohost,
    output logic [HTIF_PCR_WIDTH-1:0] fromhost,
    output logic                      htif_irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic                      rw_q, rw_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [HTIF_PCR_WIDTH-1:0] data_q, data_d;
    logic [HTIF_PCR_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [HTIF_PCR_WIDTH-1:0] tohost_q, tohost_d;
    logic [HTIF_PCR_WIDTH-1:0] fromhost_q, fromhost_d;

    logic                      host_wr_tohost;
    logic                      host_wr_fromhost;
    logic                      core_wr_tohost;
    logic                      core_wr_fromhost;
    logic [HTIF_PCR_WIDTH-1:0] host_rd_value;

    assign htif_pcr_req_ready  = reset && (state_q == ST_IDLE);
    assign htif_pcr_resp_valid = reset && (state_q == ST_RESP);
    assign htif_pcr_resp_data  = resp_data_q;
    assign tohost              = tohost_q;
    assign fromhost            = fromhost_q;
    assign htif_irq            = (fromhost_q != '0);

    assign host_wr_tohost   = (state_q == ST_ACCESS) && rw_q && (addr_q == TOHOST_ADDR);
    assign host_wr_fromhost = (state_q == ST_ACCESS) && rw_q && (addr_q == FROMHOST_ADDR);
    assign core_wr_tohost   = core_csr_wen && (core_csr_addr == TOHOST_ADDR);
    assign core_wr_fromhost = core_csr_wen && (core_csr_addr == FROMHOST_ADDR);

    // Unmapped addresses read as zero.
    assign host_rd_value = (addr_q == TOHOST_ADDR)   ? tohost_q   :
                           (addr_q == FROMHOST_ADDR) ? fromhost_q : '0;

    // On a same-cycle collision the owner wins: core owns tohost, host owns fromhost.
    assign tohost_d   = core_wr_tohost   ? core_csr_wdata :
                        host_wr_tohost   ? data_q         : tohost_q;
    assign fromhost_d = host_wr_fromhost ? data_q         :
                        core_wr_fromhost ? core_csr_wdata : fromhost_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (htif_pcr_req_valid && htif_pcr_req_ready) begin
                    rw_d    = htif_pcr_req_rw;
                    addr_d  = htif_pcr_req_addr;
                    data_d  = htif_pcr_req_data;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                resp_data_d = host_rd_value;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (htif_pcr_resp_valid && htif_pcr_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            tohost_q    <= '0;
            fromhost_q  <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_responder.sv
// Scoreboard bench for vscale_htif_pcr_responder: directed cases then randomized traffic
// checked against a register-level reference model.
module tb_vscale_htif_pcr_responder;

    localparam logic [11:0] TO_A = 12'h780;
    localparam logic [11:0] FR_A = 12'h781;
    localparam logic [11:0] UN_A = 12'h300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        htif_pcr_req_valid = 1'b0;
    logic        htif_pcr_req_ready;
    logic        htif_pcr_req_rw = 1'b0;
    logic [11:0] htif_pcr_req_addr = '0;
    logic [63:0] htif_pcr_req_data = '0;
    logic        htif_pcr_resp_valid;
    logic        htif_pcr_resp_ready = 1'b0;
    logic [63:0] htif_pcr_resp_data;
    logic        core_csr_wen = 1'b0;
    logic [11:0] core_csr_addr = '0;
    logic [63:0] core_csr_wdata = '0;
    logic [63:0] tohost;
    logic [63:0] fromhost;
    logic        htif_irq;

    vscale_htif_pcr_responder dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (htif_pcr_req_valid),
        .htif_pcr_req_ready  (htif_pcr_req_ready),
        .htif_pcr_req_rw     (htif_pcr_req_rw),
        .htif_pcr_req_addr   (htif_pcr_req_addr),
        .htif_pcr_req_data   (htif_pcr_req_data),
        .htif_pcr_resp_valid (htif_pcr_resp_valid),
        .htif_pcr_resp_ready (htif_pcr_resp_ready),
        .htif_pcr_resp_data  (htif_pcr_resp_data),
        .core_csr_wen        (core_csr_wen),
        .core_csr_addr       (core_csr_addr),
        .core_csr_wdata      (core_csr_wdata),
        .tohost              (tohost),
        .fromhost            (fromhost),
        .htif_irq            (htif_irq)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_to = '0;
    logic [63:0] m_from = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        if (a == TO_A) return m_to;
        if (a == FR_A) return m_from;
        return '0;
    endfunction

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return TO_A;
            1:       return FR_A;
            2:       return UN_A;
            default: return 12'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] rand_data();
        if ($urandom_range(0, 3) == 0) return '0;
        return {$urandom, $urandom};
    endfunction

    // Monitor: every response handshake must match the oldest expected value.
    always @(negedge clk) begin
        if (reset && htif_pcr_resp_valid && htif_pcr_resp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: got %h with no request outstanding", htif_pcr_resp_data);
            end else begin
                check("resp_data", htif_pcr_resp_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One clock edge; the model applies the register rules to the inputs sampled there.
    task automatic step(input bit access, input bit h_rw, input logic [11:0] h_addr,
                        input logic [63:0] h_data);
        logic host_to, host_fr;
        @(posedge clk);
        if (!reset) begin
            m_to   = '0;
            m_from = '0;
        end else begin
            host_to = access && h_rw && (h_addr == TO_A);
            host_fr = access && h_rw && (h_addr == FR_A);
            if (core_csr_wen && core_csr_addr == TO_A) m_to = core_csr_wdata;
            else if (host_to) m_to = h_data;
            if (host_fr) m_from = h_data;
            else if (core_csr_wen && core_csr_addr == FR_A) m_from = core_csr_wdata;
        end
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_tohost"}, tohost, m_to);
        check({tag, "_fromhost"}, fromhost, m_from);
        check({tag, "_irq"}, 64'(htif_irq), 64'(m_from != 0));
    endtask

    task automatic set_core(input bit rnd);
        core_csr_wen   = rnd && ($urandom_range(0, 3) == 0);
        core_csr_addr  = rand_addr();
        core_csr_wdata = rand_data();
    endtask

    task automatic set_junk_req(input bit rnd);
        htif_pcr_req_valid = rnd;
        htif_pcr_req_rw    = 1'($urandom);
        htif_pcr_req_addr  = rand_addr();
        htif_pcr_req_data  = rand_data();
    endtask

    task automatic core_write(input logic [11:0] a, input logic [63:0] d);
        core_csr_wen   = 1'b1;
        core_csr_addr  = a;
        core_csr_wdata = d;
        step(0, 0, '0, '0);
        core_csr_wen = 1'b0;
    endtask

    // Entered just after a rising edge with the DUT idle; returns the same way.
    task automatic do_txn(input bit rw, input logic [11:0] addr, input logic [63:0] data,
                          input int delay, input bit rnd,
                          input bit c_en, input logic [11:0] c_addr, input logic [63:0] c_data);
        logic [63:0] exp;
        int          waited;
        bit          done;
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_rw    = rw;
        htif_pcr_req_addr  = addr;
        htif_pcr_req_data  = data;
        set_core(rnd);
        @(negedge clk);
        check("idle_req_ready", 64'(htif_pcr_req_ready), 64'd1);
        check("idle_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
        check_regs("idle");
        step(0, 0, '0, '0);

        exp = model_read(addr);
        exp_q.push_back(exp);
        set_junk_req(rnd);
        core_csr_wen   = c_en;
        core_csr_addr  = c_addr;
        core_csr_wdata = c_data;
        @(negedge clk);
        check("access_req_ready", 64'(htif_pcr_req_ready), 64'd0);
        check("access_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
        step(1, rw, addr, data);

        htif_pcr_resp_ready = (delay == 0);
        set_core(rnd);
        set_junk_req(rnd);
        waited = 0;
        forever begin
            @(negedge clk);
            check("resp_valid", 64'(htif_pcr_resp_valid), 64'd1);
            check("resp_req_ready", 64'(htif_pcr_req_ready), 64'd0);
            check("resp_hold", htif_pcr_resp_data, exp);
            check_regs("resp");
            done = htif_pcr_resp_ready;
            step(0, 0, '0, '0);
            if (done) break;
            waited++;
            htif_pcr_resp_ready = (waited >= delay);
            set_core(rnd);
            set_junk_req(rnd);
        end
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_resp_ready = 1'b0;
        core_csr_wen        = 1'b0;
    endtask

    task automatic reset_in_resp();
        htif_pcr_req_valid = 1'b1;
        htif_pcr_req_rw    = 1'b0;
        htif_pcr_req_addr  = TO_A;
        step(0, 0, '0, '0);
        htif_pcr_req_valid = 1'b0;
        exp_q.push_back(model_read(TO_A));
        step(1, 0, TO_A, '0);
        htif_pcr_resp_ready = 1'b0;
        @(negedge clk);
        check("pre_reset_resp_valid", 64'(htif_pcr_resp_valid), 64'd1);
        reset = 1'b0;
        step(0, 0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
        check("post_reset_req_ready", 64'(htif_pcr_req_ready), 64'd1);
        check_regs("post_reset");
        void'(exp_q.pop_front());
        step(0, 0, '0, '0);
    endtask

    initial begin
        repeat (3) begin
            step(0, 0, '0, '0);
            @(negedge clk);
            check("rst_req_ready", 64'(htif_pcr_req_ready), 64'd0);
            check("rst_resp_valid", 64'(htif_pcr_resp_valid), 64'd0);
            check_regs("rst");
        end
        reset = 1'b1;
        step(0, 0, '0, '0);

        core_write(TO_A, 64'h1);
        do_txn(0, TO_A, '0, 0, 0, 0, '0, '0);
        core_write(TO_A, 64'h0000_0000_0000_41FF);
        do_txn(1, TO_A, '0, 0, 0, 0, '0, '0);
        do_txn(1, FR_A, 64'h5, 0, 0, 1, FR_A, 64'h7);
        do_txn(1, TO_A, 64'h3, 0, 0, 1, TO_A, 64'h9);
        do_txn(0, TO_A, '0, 0, 0, 0, '0, '0);
        do_txn(0, UN_A, '0, 0, 0, 0, '0, '0);
        do_txn(1, UN_A, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, '0, '0);
        do_txn(0, FR_A, '0, 5, 1, 0, '0, '0);

        core_write(TO_A, 64'hDEAD_BEEF_0123_4567);
        reset_in_resp();

        for (int i = 0; i < 150; i++) begin
            do_txn(1'($urandom), rand_addr(), rand_data(), $urandom_range(0, 3), 1,
                   1'($urandom), ($urandom_range(0, 1) == 0) ? TO_A : FR_A, rand_data());
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
